// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared types and bit-level cell helpers for seq_approx_divider.
//   state_e     : controller state encoding (IDLE -> CALC -> DONE)
//   exact_cell  : full subtractor cell, returns {bout, diff}
//   approx_cell : approximate subtractor cell, returns {bout, diff}
package seq_div_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Exact borrow-ripple cell: x - y - bin.
  function automatic logic [1:0] exact_cell(input logic x, input logic y, input logic bin);
    logic diff;
    logic bout;
    diff = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
    return {bout, diff};
  endfunction

  // Approximate cell: the difference ignores y, and the borrow only
  // compares y with the incoming borrow.
  function automatic logic [1:0] approx_cell(input logic x, input logic y, input logic bin);
    logic diff;
    logic bout;
    diff = x ^ bin;
    bout = ~(y ^ bin);
    return {bout, diff};
  endfunction

endpackage

// File: rtl/div_row.sv
// div_row: one combinational restoring-division row.
//   p_i         : partial remainder {rem, n[i]} (W+1 bits)
//   d_i         : divisor (W bits)
//   row_i       : current row index i
//   approx_en_i : enable approximate cells for this operation
//   q_bit_o     : resolved quotient bit for row i
//   rem_o       : next partial remainder (W bits)
module div_row
  import seq_div_pkg::*;
#(
  parameter int W            = 8,
  parameter int APPROX_DEPTH = 6,
  parameter int IW           = $clog2(W)
) (
  input  logic [W:0]    p_i,
  input  logic [W-1:0]  d_i,
  input  logic [IW-1:0] row_i,
  input  logic          approx_en_i,
  output logic          q_bit_o,
  output logic [W-1:0]  rem_o
);

  logic [W-1:0] diff_s;
  logic         borrow_s;
  logic [1:0]   cell_s;

  // Ripple the borrow across columns 0..W-1, choosing the cell type per column.
  always_comb begin
    diff_s   = '0;
    borrow_s = 1'b0;
    cell_s   = 2'b00;
    for (int j = 0; j < W; j++) begin
      if (approx_en_i && ((int'(row_i) + j) < APPROX_DEPTH)) begin
        cell_s = approx_cell(p_i[j], d_i[j], borrow_s);
      end else begin
        cell_s = exact_cell(p_i[j], d_i[j], borrow_s);
      end
      diff_s[j] = cell_s[0];
      borrow_s  = cell_s[1];
    end
    // The subtraction succeeds if P's top bit covers the final borrow.
    q_bit_o = p_i[W] | ~borrow_s;
    if (q_bit_o) begin
      rem_o = diff_s;
    end else begin
      rem_o = p_i[W-1:0];
    end
  end

endmodule

// File: rtl/seq_approx_divider.sv
// seq_approx_divider: sequential 2W/W restoring divider, one quotient bit
// per cycle, with optionally approximate low-order subtractor cells.
//   clk, rst            : clock, synchronous active-high reset
//   in_valid/in_ready   : request handshake (n_in, d_in, approx_en captured)
//   out_valid/out_ready : result handshake
//   q_out, r_out        : quotient and remainder (zero outside DONE)
//   dbz, ovf            : divide-by-zero and quotient-overflow flags
module seq_approx_divider
  import seq_div_pkg::*;
#(
  parameter int W            = 8,
  parameter int APPROX_DEPTH = 6
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] n_in,
  input  logic [W-1:0]   d_in,
  input  logic           approx_en,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   q_out,
  output logic [W-1:0]   r_out,
  output logic           dbz,
  output logic           ovf
);

  localparam int IW = $clog2(W);
  localparam logic [IW-1:0] ROW_TOP = IW'(W - 1);
  localparam logic [IW-1:0] ROW_ONE = IW'(1);

  state_e        state_q;
  logic [W-1:0]  rem_q;
  logic [W-1:0]  n_lo_q;
  logic [W-1:0]  d_q;
  logic          approx_q;
  logic [IW-1:0] row_q;
  logic [W-1:0]  quo_q;
  logic          dbz_flag_q;
  logic          ovf_flag_q;
  logic          in_ready_q;
  logic          out_valid_q;
  logic [W-1:0]  q_out_q;
  logic [W-1:0]  r_out_q;
  logic          dbz_q;
  logic          ovf_q;

  logic [W:0]    row_p_d;
  logic          row_qbit_d;
  logic [W-1:0]  row_rem_d;
  logic [W-1:0]  quo_d;

  assign row_p_d = {rem_q, n_lo_q[row_q]};
  // Quotient bits arrive MSB first, so a left shift lands them in place.
  assign quo_d   = {quo_q[W-2:0], row_qbit_d};

  div_row #(
    .W            (W),
    .APPROX_DEPTH (APPROX_DEPTH),
    .IW           (IW)
  ) u_row (
    .p_i         (row_p_d),
    .d_i         (d_q),
    .row_i       (row_q),
    .approx_en_i (approx_q),
    .q_bit_o     (row_qbit_d),
    .rem_o       (row_rem_d)
  );

  // Controller FSM, datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rem_q       <= '0;
      n_lo_q      <= '0;
      d_q         <= '0;
      approx_q    <= 1'b0;
      row_q       <= ROW_TOP;
      quo_q       <= '0;
      dbz_flag_q  <= 1'b0;
      ovf_flag_q  <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      q_out_q     <= '0;
      r_out_q     <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_valid && in_ready_q) begin
            rem_q      <= n_in[2*W-1:W];
            n_lo_q     <= n_in[W-1:0];
            d_q        <= d_in;
            approx_q   <= approx_en;
            row_q      <= ROW_TOP;
            quo_q      <= '0;
            dbz_flag_q <= (d_in == '0);
            ovf_flag_q <= (n_in[2*W-1:W] >= d_in);
            in_ready_q <= 1'b0;
            state_q    <= ST_CALC;
          end
        end
        ST_CALC: begin
          rem_q <= row_rem_d;
          quo_q <= quo_d;
          if (row_q == '0) begin
            state_q     <= ST_DONE;
            out_valid_q <= 1'b1;
            // Divide-by-zero overrides the array result; latency is unchanged.
            q_out_q     <= dbz_flag_q ? {W{1'b1}} : quo_d;
            r_out_q     <= dbz_flag_q ? n_lo_q : row_rem_d;
            dbz_q       <= dbz_flag_q;
            ovf_q       <= ovf_flag_q;
          end else begin
            row_q <= row_q - ROW_ONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            row_q       <= ROW_TOP;
            q_out_q     <= '0;
            r_out_q     <= '0;
            dbz_q       <= 1'b0;
            ovf_q       <= 1'b0;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          row_q       <= ROW_TOP;
          q_out_q     <= '0;
          r_out_q     <= '0;
          dbz_q       <= 1'b0;
          ovf_q       <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign q_out     = q_out_q;
  assign r_out     = r_out_q;
  assign dbz       = dbz_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_seq_approx_divider.sv
// Directed and randomized self-checking bench for seq_approx_divider (W=8, APPROX_DEPTH=6).
module tb_seq_approx_divider;

  localparam int W     = 8;
  localparam int DEPTH = 6;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [15:0]  n_in;
  logic [7:0]   d_in;
  logic         approx_en;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   q_out;
  logic [7:0]   r_out;
  logic         dbz;
  logic         ovf;

  int tests_run;
  int tests_failed;

  seq_approx_divider #(.W(W), .APPROX_DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .n_in      (n_in),
    .d_in      (d_in),
    .approx_en (approx_en),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .q_out     (q_out),
    .r_out     (r_out),
    .dbz       (dbz),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model written from the cell equations; returns {q, r}.
  function automatic logic [15:0] ref_div(input logic [15:0] n, input logic [7:0] d, input logic ae);
    logic [7:0] rem;
    logic [7:0] q;
    logic [8:0] p;
    logic [7:0] df;
    logic       b;
    logic       nb;
    logic       qb;
    rem = n[15:8];
    q   = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      p  = {rem, n[i]};
      b  = 1'b0;
      df = 8'h00;
      for (int j = 0; j < 8; j++) begin
        if (ae && (i + j < DEPTH)) begin
          df[j] = p[j] ^ b;
          nb    = ~(d[j] ^ b);
        end else begin
          df[j] = p[j] ^ d[j] ^ b;
          nb    = (~p[j] & d[j]) | (~(p[j] ^ d[j]) & b);
        end
        b = nb;
      end
      qb   = p[8] | ~b;
      q[i] = qb;
      rem  = qb ? df : p[7:0];
    end
    if (d == 8'h00) begin
      q   = 8'hFF;
      rem = n[7:0];
    end
    return {q, rem};
  endfunction

  // Present a request at the negedge; returns #1 after the accepting edge.
  task automatic start_op(input logic [15:0] n, input logic [7:0] d, input logic ae);
    @(negedge clk);
    check_eq("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    in_valid  = 1'b1;
    n_in      = n;
    d_in      = d;
    approx_en = ae;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Called #1 after the accepting edge; checks latency and result fields.
  task automatic wait_result(input string tag, input logic [7:0] eq, input logic [7:0] er,
                             input logic edbz, input logic eovf, input logic chk_lat);
    int cyc;
    cyc = 0;
    while (!out_valid && cyc < 50) begin
      @(posedge clk);
      cyc++;
      #1;
    end
    if (chk_lat) check_eq({tag, "_latency"}, cyc, 32'd8);
    else if (cyc >= 50) check_eq({tag, "_timeout"}, cyc, 32'd8);
    check_eq({tag, "_q"}, {24'd0, q_out}, {24'd0, eq});
    check_eq({tag, "_r"}, {24'd0, r_out}, {24'd0, er});
    check_eq({tag, "_flags"}, {30'd0, dbz, ovf}, {30'd0, edbz, eovf});
  endtask

  task automatic release_result(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq({tag, "_post_hs"}, {13'd0, out_valid, in_ready, q_out, r_out, dbz, ovf},
             {13'd0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, 1'b0});
  endtask

  task automatic run_op(input string tag, input logic [15:0] n, input logic [7:0] d, input logic ae,
                        input logic [7:0] eq, input logic [7:0] er, input logic edbz, input logic eovf);
    start_op(n, d, ae);
    wait_result(tag, eq, er, edbz, eovf, 1'b1);
    release_result(tag);
  endtask

  initial begin
    logic [15:0] rn;
    logic [7:0]  rd;
    logic        rae;
    logic [15:0] exp_qr;
    logic [15:0] ex;
    tests_run    = 0;
    tests_failed = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    n_in      = 16'h0000;
    d_in      = 8'h00;
    approx_en = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("reset_state", {13'd0, in_ready, out_valid, q_out, r_out, dbz, ovf},
             {13'd0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0});

    run_op("exact_1000_7",  16'd1000,  8'd7,  1'b0, 8'd142, 8'd6,  1'b0, 1'b0);
    run_op("approx_1000_7", 16'd1000,  8'd7,  1'b1, 8'd154, 8'd8,  1'b0, 1'b0);
    run_op("dbz_exact",     16'h1234,  8'd0,  1'b0, 8'hFF,  8'h34, 1'b1, 1'b1);
    run_op("dbz_approx",    16'h1234,  8'd0,  1'b1, 8'hFF,  8'h34, 1'b1, 1'b1);
    run_op("ovf_0900_8",    16'h0900,  8'd8,  1'b0, 8'hFF,  8'h08, 1'b0, 1'b1);
    run_op("ff_div_1",      16'h00FF,  8'd1,  1'b0, 8'hFF,  8'h00, 1'b0, 1'b0);

    // Backpressure: out_ready low 5 cycles while a new request waits.
    start_op(16'd1000, 8'd7, 1'b0);
    wait_result("bp", 8'd142, 8'd6, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_valid  = 1'b1;
      n_in      = 16'h0050;
      d_in      = 8'd5;
      approx_en = 1'b0;
      check_eq("bp_hold", {14'd0, out_valid, in_ready, q_out, r_out},
               {14'd0, 1'b1, 1'b0, 8'd142, 8'd6});
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check_eq("bp_release_no_accept", {30'd0, out_valid, in_ready}, {30'd0, 1'b0, 1'b1});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check_eq("bp_next_accepted", {31'd0, in_ready}, 32'd0);
    wait_result("bp_next", 8'd16, 8'd0, 1'b0, 1'b0, 1'b1);
    release_result("bp_next");

    // Reset during CALC aborts the operation.
    start_op(16'd1000, 8'd7, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_mid_calc", {14'd0, out_valid, in_ready, q_out, r_out},
             {14'd0, 1'b0, 1'b1, 8'h00, 8'h00});
    repeat (10) @(posedge clk);
    #1;
    check_eq("rst_no_output", {31'd0, out_valid}, 32'd0);
    run_op("after_rst", 16'h1234, 8'h56, 1'b0, 8'd54, 8'd16, 1'b0, 1'b0);

    // Randomized run against the reference model.
    for (int t = 0; t < 2000; t++) begin
      rd  = 8'($urandom_range(0, 255));
      if (t % 16 == 0) rd = 8'h00;
      rn  = 16'($urandom);
      if ((t % 2 == 0) && (rd != 8'h00)) rn[15:8] = 8'($urandom_range(0, int'(rd) - 1));
      rae = 1'($urandom_range(0, 1));
      exp_qr = ref_div(rn, rd, rae);
      start_op(rn, rd, rae);
      wait_result("rand", exp_qr[15:8], exp_qr[7:0], (rd == 8'h00), (rn[15:8] >= rd), 1'b0);
      if (!rae && (rd != 8'h00) && (rn[15:8] < rd)) begin
        ex = rn / {8'h00, rd};
        check_eq("rand_exact_q", {24'd0, q_out}, {24'd0, ex[7:0]});
        ex = rn % {8'h00, rd};
        check_eq("rand_exact_r", {24'd0, r_out}, {24'd0, ex[7:0]});
      end
      release_result("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
